// File: rtl/bus_arb_pkg.sv
// Shared constants, output payload type and helpers for the 8-way bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;

  localparam logic [NUM_REQ-1:0] GNT_NONE = 8'h00;

  // Registered arbiter outputs, kept together so they update as one word.
  typedef struct packed {
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               sw;
  } arb_out_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between the control unit requesters and the bus arbiter.
interface bus_arbiter8_if import bus_arb_pkg::*; ();

  logic [NUM_REQ-1:0] Req;
  logic [NUM_REQ-1:0] Grant;
  logic [SEL_W-1:0]   Sel;
  logic               Busy;
  logic               Switch;

  modport master (
    input  Req,
    output Grant,
    output Sel,
    output Busy,
    output Switch
  );

  modport slave (
    output Req,
    input  Grant,
    input  Sel,
    input  Busy,
    input  Switch
  );

endinterface

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request scanning from ptr upward, modulo 8.
module rr_pick8 import bus_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any_c,
  output logic [SEL_W-1:0]   idx_c
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    any_c = |req;
    idx_c = ptr + off;
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin owner of the 8:1 datapath bus mux with a per-owner hold limit.
module bus_arbiter8 import bus_arb_pkg::*; #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  bus_arbiter8_if.master bus
);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  arb_out_t          out_q, out_d;

  logic               own_req;
  logic               hold_max;
  logic [SEL_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] req_others;
  logic               idle_any, hand_any;
  logic [SEL_W-1:0]   idle_idx, hand_idx;

  assign own_req    = bus.Req[out_q.sel];
  assign hold_max   = (hold_q == HOLD_W'(MAX_HOLD));
  assign next_ptr   = out_q.sel + SEL_W'(1);
  assign req_others = bus.Req & ~out_q.grant;

  // Fresh grant out of IDLE uses the stored pointer.
  rr_pick8 u_pick_idle (
    .req   (bus.Req),
    .ptr   (ptr_q),
    .any_c (idle_any),
    .idx_c (idle_idx)
  );

  // Hand-off candidate: everyone but the owner, scanning from owner+1.
  rr_pick8 u_pick_hand (
    .req   (req_others),
    .ptr   (next_ptr),
    .any_c (hand_any),
    .idx_c (hand_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    out_d      = out_q;
    out_d.sw   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        out_d.grant = GNT_NONE;
        out_d.busy  = 1'b0;
        if (idle_any) begin
          out_d.grant = onehot(idle_idx);
          out_d.sel   = idle_idx;
          out_d.busy  = 1'b1;
          out_d.sw    = 1'b1;
          hold_d      = HOLD_W'(1);
          state_d     = ST_OWN;
        end
      end

      ST_OWN: begin
        // Release wins over expiry when both happen on the same edge.
        if (!own_req || hold_max) begin
          ptr_d = next_ptr;
          if (hand_any) begin
            out_d.grant = onehot(hand_idx);
            out_d.sel   = hand_idx;
            out_d.sw    = 1'b1;
            hold_d      = HOLD_W'(1);
          end else if (!own_req) begin
            out_d.grant = GNT_NONE;
            out_d.busy  = 1'b0;
            hold_d      = '0;
            state_d     = ST_IDLE;
          end else begin
            hold_d = HOLD_W'(1);
          end
        end else if (hold_q < HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        out_d.grant = GNT_NONE;
        out_d.busy  = 1'b0;
        hold_d      = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign bus.Grant  = out_q.grant;
  assign bus.Sel    = out_q.sel;
  assign bus.Busy   = out_q.busy;
  assign bus.Switch = out_q.sw;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Scoreboard bench for bus_arbiter8 against an integer round-robin reference model.
module tb_bus_arbiter8;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       sw;
  } exp_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  bus_arbiter8_if bus ();

  bus_arbiter8 #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;

  int wait_cnt[8];
  int max_wait = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
    end
  endfunction

  function automatic int pick(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endfunction

  // One clock edge of the arbitration rules; pushes the outputs expected after it.
  function automatic void model_step(input logic [7:0] r);
    exp_t e;
    int   p;
    logic sw;
    sw = 1'b0;
    if (m_owner < 0) begin
      p = pick(r, m_ptr, -1);
      if (p >= 0) begin
        m_owner = p; m_hold = 1; m_sel = p; sw = 1'b1;
      end
    end else if (!r[m_owner] || m_hold == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 8;
      p = pick(r, m_ptr, m_owner);
      if (p >= 0) begin
        m_owner = p; m_hold = 1; m_sel = p; sw = 1'b1;
      end else if (!r[m_owner]) begin
        m_owner = -1;
      end else begin
        m_hold = 1;
      end
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
    e.grant = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
    e.sel   = 3'(m_sel);
    e.busy  = (m_owner >= 0);
    e.sw    = sw;
    sbq.push_back(e);
  endfunction

  task automatic drive(input logic [7:0] r);
    @(negedge Clk);
    bus.Req = r;
    model_step(r);
  endtask

  // Assert reset between edges and check the outputs drop without a clock.
  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset   = 1'b1;
    bus.Req = 8'h00;
    #1;
    chk("rst_grant",  32'(bus.Grant),  32'h0);
    chk("rst_sel",    32'(bus.Sel),    32'h0);
    chk("rst_busy",   32'(bus.Busy),   32'h0);
    chk("rst_switch", 32'(bus.Switch), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    sbq.delete();
  endtask

  // Monitor: pop expectations, check invariants, track per-requester waiting.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_grant",  32'(bus.Grant),  32'(e.grant));
      chk("sb_sel",    32'(bus.Sel),    32'(e.sel));
      chk("sb_busy",   32'(bus.Busy),   32'(e.busy));
      chk("sb_switch", 32'(bus.Switch), 32'(e.sw));
    end
    if (!Reset) begin
      chk("inv_onehot0", 32'($onehot0(bus.Grant)), 32'h1);
      chk("inv_busy_or", 32'(bus.Busy), 32'(|bus.Grant));
      if (bus.Busy) chk("inv_grant_sel", 32'(bus.Grant[bus.Sel]), 32'h1);
      for (int i = 0; i < 8; i++) begin
        if (bus.Req[i] && !bus.Grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    bus.Req = 8'h00;
    Reset   = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("por_grant",  32'(bus.Grant),  32'h0);
    chk("por_sel",    32'(bus.Sel),    32'h0);
    chk("por_busy",   32'(bus.Busy),   32'h0);
    chk("por_switch", 32'(bus.Switch), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    // Reset while requester 2 owns the bus, then stay idle.
    repeat (3) drive(8'h04);
    do_reset();
    repeat (3) drive(8'h00);

    // Single requester through one expiry with no contender.
    repeat (6) drive(8'h08);
    repeat (3) drive(8'h00);

    // Full contention: every owner in turn for MAX_HOLD cycles.
    do_reset();
    repeat (9 * MAX_HOLD + 2) drive(8'hFF);
    repeat (2) drive(8'h00);

    // Early hand-off 2 -> 5, then wrap priority 6 before 0.
    do_reset();
    repeat (3) drive(8'h24);
    repeat (2) drive(8'h20);
    repeat (3) drive(8'h41);
    repeat (3) drive(8'h01);
    repeat (2) drive(8'h00);

    // Random sweep: a sparse free-running phase, then held-until-served requests.
    r = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      if (c < 400) begin
        r = 8'($urandom) & 8'($urandom);
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (r[i]) begin
            if (m_owner == i && $urandom_range(0, 5) == 0) r[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            r[i] = 1'b1;
          end
        end
      end
      drive(r);
    end
    repeat (2) drive(8'h00);

    @(posedge Clk);
    #3;
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    checks++;
    if (max_wait > 7 * MAX_HOLD) begin
      errors++;
      $display("FAIL starvation: longest wait %0d cycles, limit %0d", max_wait, 7 * MAX_HOLD);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
